// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: multi-cycle, non-pipelined control unit in front of a 32-bit ALU.
// Accepts one instruction over valid/ready, reads an 8x32 register file, drives the
// ALU, captures result/flags and writes back. R0 reads as zero and ignores writes.
module alu_ctrl_unit #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [5:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_LOADI = 6'b000001;
  localparam logic [5:0] OP_ADD   = 6'b010000;
  localparam logic [5:0] OP_SUB   = 6'b010001;
  localparam logic [5:0] OP_EQ    = 6'b100000;
  localparam logic [5:0] OP_NE    = 6'b100001;
  localparam logic [5:0] OP_LE    = 6'b100010;
  localparam logic [5:0] OP_GT    = 6'b100011;
  localparam logic [5:0] OP_LLS   = 6'b110000;
  localparam logic [5:0] OP_LRS   = 6'b110001;
  localparam logic [5:0] OP_ARS   = 6'b110010;

  state_t              state;
  logic [5:0]          op_q;
  logic [2:0]          rd_q;
  logic [2:0]          rs1_q;
  logic [2:0]          rs2_q;
  logic [IMM_W-1:0]    imm_q;
  logic [DATA_W-1:0]   rf [8];
  logic [DATA_W-1:0]   res_h;
  logic                cout_h;
  logic                z_h;
  logic                n_h;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
  logic                unused_bits;

  // Instruction bit 16 sits between rs2 and imm and carries nothing.
  assign unused_bits = instr[16];

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT, OP_LLS, OP_LRS, OP_ARS: is_alu_op = 1'b1;
      default: is_alu_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_addsub(input logic [5:0] op);
    is_addsub = (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    is_legal = is_alu_op(op) || (op == OP_LOADI) || (op == OP_NOP);
  endfunction

  // Register-file reads with R0 hardwired to zero.
  always_comb begin
    rs1_data = (rs1_q == 3'd0)    ? '0 : rf[rs1_q];
    rs2_data = (rs2_q == 3'd0)    ? '0 : rf[rs2_q];
    dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Control FSM, operand/result registers, register file and flag updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      rf     <= '{default: '0};
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      res_h  <= '0;
      cout_h <= 1'b0;
      z_h    <= 1'b0;
      n_h    <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr[31:26];
            rd_q  <= instr[25:23];
            rs1_q <= instr[22:20];
            rs2_q <= instr[19:17];
            imm_q <= instr[IMM_W-1:0];
            state <= DECODE;
          end
        end
        DECODE: begin
          if (is_alu_op(op_q)) begin
            alu_op <= op_q;
            alu_a  <= rs1_data;
            alu_b  <= rs2_data;
            state  <= EXEC;
          end else begin
            done  <= 1'b1;
            err   <= !is_legal(op_q);
            state <= WB;
          end
        end
        EXEC: begin
          res_h  <= alu_result;
          cout_h <= alu_cout;
          z_h    <= alu_z;
          n_h    <= alu_n;
          done   <= 1'b1;
          state  <= WB;
        end
        WB: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
          if (is_alu_op(op_q)) begin
            if (rd_q != 3'd0) rf[rd_q] <= res_h;
            flag_z <= z_h;
            flag_n <= n_h;
            if (is_addsub(op_q)) flag_c <= cout_h;
          end else if (op_q == OP_LOADI) begin
            if (rd_q != 3'd0) rf[rd_q] <= {{(DATA_W-IMM_W){1'b0}}, imm_q};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed testbench for alu_ctrl_unit. The bench plays the ALU by driving fixed
// result/flag values per instruction and checks latency, operands, write-back and flags.
module tb_alu_ctrl_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic        alu_z;
  logic        alu_n;
  logic        busy;
  logic        done;
  logic        err;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;

  alu_ctrl_unit #(.DATA_W(32), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_z(alu_z), .alu_n(alu_n),
    .busy(busy), .done(done), .err(err),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    mk = {op, rd, rs1, rs2, 1'b0, imm};
  endfunction

  task automatic check_reg(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp_znc);
    check(tag, {29'd0, flag_z, flag_n, flag_c}, {29'd0, exp_znc});
  endtask

  // Issue one instruction, time done from the accept edge, capture EXEC-cycle ALU drive.
  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] res,
                     input logic c, input logic z, input logic n,
                     input int exp_lat, input logic exp_err);
    int cyc;
    int guard;
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    alu_result = res; alu_cout = c; alu_z = z; alu_n = n;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      if (cyc == 2) begin
        ex_op = alu_op; ex_a = alu_a; ex_b = alu_b;
      end
      if (done) break;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " ready after"}, 32'(instr_ready), 32'd1);
  endtask

  localparam logic [5:0] NOP = 6'b000000, LDI = 6'b000001, ADD = 6'b010000,
                         SUB = 6'b010001, EQ = 6'b100000, GT = 6'b100011;

  initial begin : stim
    int cyc;
    int guard;
    int done_seen;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    alu_result = '0; alu_cout = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
    ex_op = '0; ex_a = '0; ex_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst ready", 32'(instr_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", {30'd0, done, err}, 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check_flags("rst flags", 3'b000);
    check_reg("rst r3", 3'd3, 32'd0);

    // 1: LOADI r1,5
    run("ldi r1", mk(LDI, 3'd1, 3'd0, 3'd0, 16'h0005), 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    check_reg("ldi r1 val", 3'd1, 32'h0000_0005);
    check_flags("ldi flags", 3'b000);
    run("ldi r2", mk(LDI, 3'd2, 3'd0, 3'd0, 16'h0001), 32'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);

    // SUB r1,r0,r2 -> bench ALU gives 0xFFFFFFFF with borrow, N=1
    run("sub", mk(SUB, 3'd1, 3'd0, 3'd2, 16'h0), 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 3, 1'b0);
    check("sub op", 32'(ex_op), 32'(SUB));
    check("sub a", ex_a, 32'd0);
    check("sub b", ex_b, 32'd1);
    check_reg("sub r1", 3'd1, 32'hFFFF_FFFF);
    check_flags("sub flags", 3'b011);

    // 2: ADD r3,r1,r2 -> 0 with carry
    run("add", mk(ADD, 3'd3, 3'd1, 3'd2, 16'h0), 32'h0, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    check("add op", 32'(ex_op), 32'(ADD));
    check("add a", ex_a, 32'hFFFF_FFFF);
    check("add b", ex_b, 32'd1);
    check_reg("add r3", 3'd3, 32'd0);
    check_flags("add flags", 3'b101);

    // 3: GT r4,r1,r2 with R1=5, R2=7 -> 0, Z=1, C kept
    run("ldi r1b", mk(LDI, 3'd1, 3'd0, 3'd0, 16'h0005), 32'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run("ldi r2b", mk(LDI, 3'd2, 3'd0, 3'd0, 16'h0007), 32'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    check_flags("ldi keeps flags", 3'b101);
    run("gt", mk(GT, 3'd4, 3'd1, 3'd2, 16'h0), 32'h0, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    check("gt a", ex_a, 32'd5);
    check("gt b", ex_b, 32'd7);
    check_reg("gt r4", 3'd4, 32'd0);
    check_flags("gt flags", 3'b101);
    run("eq", mk(EQ, 3'd4, 3'd1, 3'd1, 16'h0), 32'h1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    check("eq b", ex_b, 32'd5);
    check_reg("eq r4", 3'd4, 32'd1);
    check_flags("eq flags", 3'b001);

    // 4: illegal opcode -> err with done at T+2, nothing changes
    run("ill", mk(6'b111111, 3'd4, 3'd1, 3'd2, 16'hFFFF), 32'h0, 1'b0, 1'b1, 1'b1, 2, 1'b1);
    check_reg("ill r4", 3'd4, 32'd1);
    check_flags("ill flags", 3'b001);
    run("nop", mk(NOP, 3'd4, 3'd0, 3'd0, 16'h00FF), 32'h0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    check_reg("nop r4", 3'd4, 32'd1);
    check_flags("nop flags", 3'b001);

    // 5: R0 hardwired; rd==rs1 reads the old value
    run("ldi r0", mk(LDI, 3'd0, 3'd0, 3'd0, 16'h1234), 32'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    check_reg("r0 zero", 3'd0, 32'd0);
    run("add rd=rs1", mk(ADD, 3'd1, 3'd1, 3'd2, 16'h0), 32'd12, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    check("rd=rs1 a", ex_a, 32'd5);
    check_reg("rd=rs1 r1", 3'd1, 32'd12);
    check_flags("rd=rs1 flags", 3'b000);

    // 6a: instr_valid held while busy is accepted only at the next IDLE
    @(negedge clk);
    instr = mk(LDI, 3'd6, 3'd0, 3'd0, 16'h00AA); instr_valid = 1'b1;
    guard = 0;
    while (!instr_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    instr = mk(LDI, 3'd7, 3'd0, 3'd0, 16'h00BB);
    check("held not ready", 32'(instr_ready), 32'd0);
    cyc = 1;
    while (!done && cyc < 8) begin @(negedge clk); cyc++; end
    check("held first done", 32'(cyc), 32'd2);
    @(negedge clk); cyc++;
    check("held reaccept ready", 32'(instr_ready), 32'd1);
    check_reg("held r6", 3'd6, 32'h0000_00AA);
    @(negedge clk); cyc++;
    instr_valid = 1'b0;
    check("held second busy", 32'(busy), 32'd1);
    while (!done && cyc < 12) begin @(negedge clk); cyc++; end
    check("held second done", 32'(cyc), 32'd5);
    @(negedge clk);
    check_reg("held r7", 3'd7, 32'h0000_00BB);

    // 6b: reset during EXEC abandons the instruction
    @(negedge clk);
    instr = mk(ADD, 3'd5, 3'd1, 3'd2, 16'h0); instr_valid = 1'b1;
    alu_result = 32'h55; alu_cout = 1'b1; alu_z = 1'b0; alu_n = 1'b1;
    guard = 0;
    while (!instr_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("mid exec op", 32'(alu_op), 32'(ADD));
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mid rst no done", 32'(done_seen), 32'd0);
    check("mid rst ready", 32'(instr_ready), 32'd1);
    check("mid rst alu_op", 32'(alu_op), 32'd0);
    check_flags("mid rst flags", 3'b000);
    check_reg("mid rst r5", 3'd5, 32'd0);
    check_reg("mid rst r1", 3'd1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
